wb_initiator: RTL and testbench

- Single-outstanding, big-endian Wishbone classic initiator. It turns a valid/ready command (address, size, write data) into one bus cycle and returns read data or an error on a valid/ready response channel.
- It drives the flash emulator and other simulation responders in bench tops.
- It is also the bus front-end for the CPU load/store path.
- It performs byte-lane steering, retry on rty_i, and optional timeout.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_be_lanes.sv | 24 ++
 rtl/wb_initiator.sv | 135 +++++++++++++
 tb/tb_wb_initiator.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone access-size and state types plus byte-lane helpers
package wb_pkg;
    typedef enum logic [1:0] {
        WB_SIZE_BYTE = 2'd0,
        WB_SIZE_HALF = 2'd1,
        WB_SIZE_WORD = 2'd2
    } wb_size_e;

    typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} wb_state_e;

    function automatic logic [3:0] wb_sel(input logic [1:0] size, input logic [1:0] off);
        return size == WB_SIZE_BYTE ? 4'b1000 >> off :
               size == WB_SIZE_HALF ? (off[1] ? 4'b0011 : 4'b1100) :
               size == WB_SIZE_WORD ? 4'b1111 : 4'b0000;
    endfunction

    function automatic logic wb_misaligned(input logic [1:0] size, input logic [1:0] off);
        return size == 2'd3 || (size == WB_SIZE_HALF && off[0]) || (size == WB_SIZE_WORD && off != 2'd0);
    endfunction
endpackage

// File: rtl/wb_be_lanes.sv
// wb_be_lanes: big-endian write-data steering and read-data extract/extend
module wb_be_lanes
    import wb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sgn,
    input  logic [31:0] wdat,
    input  logic [31:0] rdat,
    output logic [31:0] wlane,
    output logic [31:0] rext
);
    logic [4:0]  sh;
    logic [31:0] rs;

    // replicate write data across lanes; shift the addressed read lane down and extend it
    always_comb begin
        wlane = size == WB_SIZE_BYTE ? {4{wdat[7:0]}} : size == WB_SIZE_HALF ? {2{wdat[15:0]}} : wdat;
        sh    = size == WB_SIZE_BYTE ? {~off, 3'b000} : size == WB_SIZE_HALF ? {~off[1], 4'b0000} : 5'd0;
        rs    = rdat >> sh;
        rext  = size == WB_SIZE_BYTE ? {{24{sgn & rs[7]}}, rs[7:0]} :
                size == WB_SIZE_HALF ? {{16{sgn & rs[15]}}, rs[15:0]} : rs;
    end
endmodule

// File: rtl/wb_initiator.sv
// wb_initiator: single-outstanding big-endian Wishbone classic initiator (optional timeout: WB_INITIATOR_TIMEOUT_EN)
module wb_initiator
    import wb_pkg::*;
#(
    parameter int MAX_RETRIES = 3
`ifdef WB_INITIATOR_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [1:0]  cmd_size_i,
    input  logic        cmd_signed_i,
    input  logic [31:0] cmd_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i
);
    localparam int RW = $clog2(MAX_RETRIES + 2);

    wb_state_e     state;
    logic [1:0]    size_q, off_q;
    logic          sgn_q;
    logic [RW-1:0] rty_cnt;
    logic [31:0]   wlane, rext;
    logic          tmo;

`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    assign tmo = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
    assign tmo = 1'b0;
`endif

    assign cmd_ready_o = state == IDLE;

    wb_be_lanes u_lanes (
        .size  (state == IDLE ? cmd_size_i : size_q),
        .off   (state == IDLE ? cmd_adr_i[1:0] : off_q),
        .sgn   (sgn_q),
        .wdat  (cmd_dat_i),
        .rdat  (dat_i),
        .wlane (wlane),
        .rext  (rext)
    );

    // command/bus/response sequencer with registered bus and response outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= '0;
            sel_o       <= '0;
            dat_o       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_dat_o   <= '0;
            size_q      <= '0;
            off_q       <= '0;
            sgn_q       <= 1'b0;
            rty_cnt     <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
`ifdef WB_INITIATOR_TIMEOUT_EN
            tmo_cnt <= state == BUS ? tmo_cnt + 1'b1 : '0;
`endif
            case (state)
                IDLE: if (cmd_valid_i) begin
                    size_q <= cmd_size_i;
                    off_q  <= cmd_adr_i[1:0];
                    sgn_q  <= cmd_signed_i;
                    if (wb_misaligned(cmd_size_i, cmd_adr_i[1:0])) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_dat_o   <= '0;
                        state       <= RESP;
                    end else begin
                        adr_o <= {cmd_adr_i[31:2], 2'b00};
                        sel_o <= wb_sel(cmd_size_i, cmd_adr_i[1:0]);
                        dat_o <= wlane;
                        we_o  <= cmd_we_i;
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        state <= BUS;
                    end
                end
                BUS: if (ack_i || err_i || (rty_i && rty_cnt == RW'(MAX_RETRIES)) || tmo) begin
                    cyc_o       <= 1'b0;
                    stb_o       <= 1'b0;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= !ack_i;
                    rsp_dat_o   <= ack_i && !we_o ? rext : '0;
                    state       <= RESP;
                end else if (rty_i) begin
                    rty_cnt <= rty_cnt + 1'b1;
                    cyc_o   <= 1'b0;
                    stb_o   <= 1'b0;
                    state   <= GAP;
                end
                GAP: begin
                    cyc_o <= 1'b1;
                    stb_o <= 1'b1;
                    state <= BUS;
                end
                RESP: if (rsp_ready_i) begin
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    rsp_dat_o   <= '0;
                    rty_cnt     <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: randomized bench for wb_initiator with a byte-addressed reference model
module tb_wb_initiator;
    localparam int MAXR = 3;
`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam int TMO = 8;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_adr_i = '0;
    logic [1:0]  cmd_size_i = '0;
    logic        cmd_signed_i = 1'b0;
    logic [31:0] cmd_dat_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i = '0;
    logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;

    always #5 clk_i = ~clk_i;

    wb_initiator #(
        .MAX_RETRIES(MAXR)
`ifdef WB_INITIATOR_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_size_i(cmd_size_i), .cmd_signed_i(cmd_signed_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] resp_mem [64];
    logic [7:0]  ref_mem [256];

    int p_dly = 0, p_rty = 0, p_fin = 0;
    int b_start = 0;
    int bursts = 0, cnt_in = 0, low_cnt = 0, hi_len = 0, last_hi = 0;
    logic prev_cyc = 1'b0;
    logic [3:0]  last_sel = '0;
    logic [31:0] last_dat = '0;

    logic        armed = 1'b0;
    logic        e_nobus = 1'b0, e_we = 1'b0, e_err = 1'b0;
    logic [3:0]  e_sel = '0;
    logic [31:0] e_adr = '0, e_dat = '0, e_rdat = '0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // responder: flash-like memory with per-command delay, retry count and final termination
    always @(negedge clk_i) begin
        ack_i = 1'b0;
        err_i = 1'b0;
        rty_i = 1'b0;
        dat_i = $urandom;
        if (cyc_o && stb_o) begin
            if (!prev_cyc) begin
                if (bursts > b_start) chk("gap_len", low_cnt, 1);
                bursts++;
                cnt_in = 0;
                hi_len = 0;
            end
            cnt_in++;
            hi_len++;
            last_sel = sel_o;
            last_dat = dat_o;
            if (cnt_in > p_dly) begin
                if (bursts - b_start <= p_rty) rty_i = 1'b1;
                else if (p_fin == 0) begin
                    ack_i = 1'b1;
                    dat_i = resp_mem[adr_o[7:2]];
                    if (we_o)
                        for (int i = 0; i < 4; i++)
                            if (sel_o[i]) resp_mem[adr_o[7:2]][8*i +: 8] = dat_o[8*i +: 8];
                end else if (p_fin == 1) err_i = 1'b1;
            end
        end else begin
            if (prev_cyc) begin
                last_hi = hi_len;
                low_cnt = 0;
            end
            low_cnt++;
            if ($urandom_range(3) == 0) {ack_i, err_i, rty_i} = 3'($urandom);
        end
        prev_cyc = cyc_o;
    end

    // compare process: bus outputs and response against the model every meaningful cycle
    always @(negedge clk_i) begin
        if (armed) begin
            chk("ready_busy", cmd_ready_o, 1'b0);
            if (cyc_o || stb_o) begin
                if (e_nobus) chk("no_bus", {cyc_o, stb_o}, 2'b00);
                else chk("bus", {cyc_o, stb_o, we_o, sel_o, adr_o, dat_o}, {2'b11, e_we, e_sel, e_adr, e_dat});
            end
            if (rsp_valid_o) chk("rsp", {rsp_err_o, rsp_dat_o}, {e_err, e_rdat});
        end
    end

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        resp_mem[a[7:2]] = v;
        for (int b = 0; b < 4; b++) ref_mem[{a[7:2], 2'(b)}] = v[31-8*b -: 8];
    endtask

    task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [1:0] size, input logic sgn,
                          input logic [31:0] dat, input int dly, input int nrty, input int fin,
                          output logic [31:0] r_dat, output logic r_err, output int lat, output int nb_seen);
        int n, nb, off;
        logic [31:0] v;
        off = int'(adr[1:0]);
        n = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
        e_nobus = size == 2'd3 || (off % n) != 0;
        for (int i = 0; i < 4; i++) e_sel[3-i] = i >= off && i < off + n;
        e_dat = n == 1 ? {4{dat[7:0]}} : n == 2 ? {2{dat[15:0]}} : dat;
        e_adr = adr & ~32'd3;
        e_we = we;
        if (e_nobus) begin
            e_err = 1'b1;
            nb = 0;
        end else if (nrty > MAXR) begin
            e_err = 1'b1;
            nb = MAXR + 1;
        end else begin
            e_err = fin != 0;
            nb = nrty + 1;
        end
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[8'(adr + 32'(i))]);
        e_rdat = (e_err || we) ? 32'd0 : (sgn && v[8*n-1]) ? v | (32'hFFFF_FFFF << (8*n)) : v;
        if (we && !e_err)
            for (int i = 0; i < n; i++) ref_mem[8'(adr + 32'(i))] = 8'(dat >> (8*(n-1-i)));
        p_dly = dly;
        p_rty = nrty;
        p_fin = fin;
        b_start = bursts;
        @(posedge clk_i) #1;
        cmd_we_i = we;
        cmd_adr_i = adr;
        cmd_size_i = size;
        cmd_signed_i = sgn;
        cmd_dat_i = dat;
        cmd_valid_i = 1'b1;
        @(posedge clk_i) #1;
        cmd_valid_i = 1'b0;
        cmd_dat_i = $urandom;
        cmd_adr_i = $urandom;
        cmd_size_i = 2'($urandom);
        cmd_we_i = 1'($urandom);
        armed = 1'b1;
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!rsp_valid_o && lat < 400);
        if (!rsp_valid_o) begin
            chk("rsp_wait", rsp_valid_o, 1'b1);
            armed = 1'b0;
            rst_ni = 1'b0;
            #1 rst_ni = 1'b1;
            r_dat = '0;
            r_err = 1'b0;
            nb_seen = bursts - b_start;
            return;
        end
        repeat ($urandom_range(2)) @(negedge clk_i);
        r_dat = rsp_dat_o;
        r_err = rsp_err_o;
        rsp_ready_i = 1'b1;
        @(posedge clk_i) #1;
        rsp_ready_i = 1'b0;
        armed = 1'b0;
        nb_seen = bursts - b_start;
        chk("bursts", nb_seen, nb);
        chk("ready_idle", cmd_ready_o, 1'b1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        re;
        int          lat, nb, fin, sz;
        logic [31:0] a;
        logic        seen;
        for (int w = 0; w < 64; w++) set_word(32'(w) << 2, $urandom);
        repeat (3) @(negedge clk_i);
        chk("reset_ctl", {cyc_o, stb_o, we_o, rsp_valid_o, rsp_err_o, cmd_ready_o}, 6'b000001);
        chk("reset_dat", {adr_o, sel_o, dat_o, rsp_dat_o}, '0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_reset", {cyc_o, rsp_valid_o, cmd_ready_o}, 3'b001);

        do_cmd(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 1, 0, 0, rd, re, lat, nb);
        chk("wr_word_sel", {last_sel, last_dat, re}, {4'b1111, 32'hDEADBEEF, 1'b0});
        do_cmd(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1, 0, 0, rd, re, lat, nb);
        chk("rd_word", {rd, re}, {32'hDEADBEEF, 1'b0});
        chk("rd_latency", lat, 3);

        set_word(32'h100, 32'h11823344);
        do_cmd(1'b0, 32'h101, 2'd0, 1'b0, 32'h0, 0, 0, 0, rd, re, lat, nb);
        chk("rd_byte_u", {last_sel, rd}, {4'b0100, 32'h00000082});
        do_cmd(1'b0, 32'h101, 2'd0, 1'b1, 32'h0, 2, 0, 0, rd, re, lat, nb);
        chk("rd_byte_s", rd, 32'hFFFFFF82);

        set_word(32'h100, 32'h11223344);
        do_cmd(1'b1, 32'h102, 2'd1, 1'b0, 32'h0000ABCD, 0, 0, 0, rd, re, lat, nb);
        chk("wr_half_lane", {last_sel, last_dat}, {4'b0011, 32'hABCDABCD});
        do_cmd(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1, 0, 0, rd, re, lat, nb);
        chk("rd_after_half", rd, 32'h1122ABCD);

        do_cmd(1'b0, 32'h103, 2'd1, 1'b0, 32'h0, 0, 0, 0, rd, re, lat, nb);
        chk("misaligned", {re, rd, 32'(nb)}, {1'b1, 32'h0, 32'd0});

        do_cmd(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 0, 4, 0, rd, re, lat, nb);
        chk("rty_exhaust", {re, 32'(nb)}, {1'b1, 32'd4});
        do_cmd(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1, 2, 0, rd, re, lat, nb);
        chk("rty_then_ack", {re, rd, 32'(nb)}, {1'b0, 32'h1122ABCD, 32'd3});

`ifdef WB_INITIATOR_TIMEOUT_EN
        do_cmd(1'b0, 32'h104, 2'd2, 1'b0, 32'h0, 0, 0, 2, rd, re, lat, nb);
        chk("timeout", {re, 32'(last_hi)}, {1'b1, 32'd8});
`endif

        for (int it = 0; it < 160; it++) begin
            sz = $urandom_range(9) == 0 ? 3 : $urandom_range(2);
            a = $urandom;
            if ($urandom_range(3) != 0) a = sz == 2 ? a & ~32'd3 : sz == 1 ? a & ~32'd1 : a;
            fin = $urandom_range(9) < 7 ? 0 : 1;
`ifdef WB_INITIATOR_TIMEOUT_EN
            if ($urandom_range(9) == 0) fin = 2;
`endif
            do_cmd(1'($urandom), a, 2'(sz), 1'($urandom), $urandom, $urandom_range(2),
                   $urandom_range(3) == 0 ? $urandom_range(MAXR + 1) : 0, fin, rd, re, lat, nb);
        end

        p_dly = 0;
        p_rty = 0;
        p_fin = 2;
        b_start = bursts;
        @(posedge clk_i) #1;
        cmd_we_i = 1'b0;
        cmd_adr_i = 32'h200;
        cmd_size_i = 2'd2;
        cmd_valid_i = 1'b1;
        @(posedge clk_i) #1;
        cmd_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1 chk("rst_async", {cyc_o, stb_o}, 2'b00);
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk_i);
            seen = seen | rsp_valid_o | cyc_o;
        end
        chk("rst_no_rsp", {seen, cmd_ready_o}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
